// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Hardwired fetch/execute control FSM for the register-to-register datapath.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int NUM_REGS    = 16,
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_rdy,
    output logic                PC_out,
    output logic                Zlo_out,
    output logic                Zhi_out,
    output logic                MDR_out,
    output logic                MAR_rd,
    output logic                PC_rd,
    output logic                MDR_rd,
    output logic                IR_rd,
    output logic                Y_rd,
    output logic                Z_rd,
    output logic                HI_rd,
    output logic                LO_rd,
    output logic                IncPC,
    output logic                Read,
    output logic [NUM_REGS-1:0] R_rd,
    output logic [NUM_REGS-1:0] R_wrt,
    output logic [OPC_W-1:0]    op_sel,
    output logic                busy,
    output logic                instr_done,
    output logic                halted,
    output logic [1:0]          fault
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [1:0]          FLT_NONE    = 2'b00;
    localparam logic [1:0]          FLT_ILLEGAL = 2'b01;
    localparam logic [1:0]          FLT_TIMEOUT = 2'b10;
    localparam logic [7:0]          WAIT_LIMIT  = 8'(MEM_TIMEOUT);
    localparam logic [NUM_REGS-1:0] REG_ONE     = NUM_REGS'(1);

    state_t     state, state_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic [1:0] fault_nx;
    logic       end_instr;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       cls_alu, cls_muldiv, cls_unary, cls_nop, cls_halt;
    logic       unused_ir_bits;

    assign opc            = ir[31:27];
    assign ra             = ir[26:23];
    assign rb             = ir[22:19];
    assign rc             = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    assign cls_alu    = (opc <= 5'd8);
    assign cls_muldiv = (opc == 5'd15) || (opc == 5'd16);
    assign cls_unary  = (opc == 5'd17) || (opc == 5'd18);
    assign cls_nop    = (opc == 5'd26);
    assign cls_halt   = (opc == 5'd27);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            fault    <= FLT_NONE;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            fault    <= fault_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        fault_nx    = fault;
        end_instr   = 1'b0;
        PC_out      = 1'b0;
        Zlo_out     = 1'b0;
        Zhi_out     = 1'b0;
        MDR_out     = 1'b0;
        MAR_rd      = 1'b0;
        PC_rd       = 1'b0;
        MDR_rd      = 1'b0;
        IR_rd       = 1'b0;
        Y_rd        = 1'b0;
        Z_rd        = 1'b0;
        HI_rd       = 1'b0;
        LO_rd       = 1'b0;
        IncPC       = 1'b0;
        Read        = 1'b0;
        R_rd        = '0;
        R_wrt       = '0;
        op_sel      = '0;
        instr_done  = 1'b0;
        busy        = (state != S_IDLE) && (state != S_HALT);
        halted      = (state == S_HALT);

        case (state)
            S_IDLE: begin
                if (run) state_nx = S_T0;
            end
            S_T0: begin
                PC_out      = 1'b1;
                MAR_rd      = 1'b1;
                IncPC       = 1'b1;
                Z_rd        = 1'b1;
                wait_cnt_nx = 8'd0;
                state_nx    = S_T1;
            end
            S_T1: begin
                // The incremented PC is latched once; later wait cycles only hold the read.
                Zlo_out = 1'b1;
                PC_rd   = (wait_cnt == 8'd0);
                Read    = 1'b1;
                MDR_rd  = 1'b1;
                if (mem_rdy) begin
                    state_nx = S_T2;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nx = S_HALT;
                    fault_nx = FLT_TIMEOUT;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                end
            end
            S_T2: begin
                MDR_out  = 1'b1;
                IR_rd    = 1'b1;
                state_nx = S_T3;
            end
            S_T3: begin
                if (cls_nop) begin
                    end_instr = 1'b1;
                end else if (cls_halt) begin
                    state_nx = S_HALT;
                end else if (!(cls_alu || cls_muldiv || cls_unary)) begin
                    state_nx = S_HALT;
                    fault_nx = FLT_ILLEGAL;
                end else begin
                    R_wrt    = REG_ONE << rb;
                    Y_rd     = 1'b1;
                    state_nx = S_T4;
                end
            end
            S_T4: begin
                R_wrt    = REG_ONE << (cls_unary ? rb : rc);
                op_sel   = ir[31 -: OPC_W];
                Z_rd     = 1'b1;
                state_nx = S_T5;
            end
            S_T5: begin
                Zlo_out = 1'b1;
                if (cls_muldiv) begin
                    LO_rd    = 1'b1;
                    state_nx = S_T6;
                end else begin
                    R_rd      = REG_ONE << ra;
                    end_instr = 1'b1;
                end
            end
            S_T6: begin
                Zhi_out   = 1'b1;
                HI_rd     = 1'b1;
                end_instr = 1'b1;
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (end_instr) begin
            instr_done = 1'b1;
            state_nx   = run ? S_T0 : S_IDLE;
        end
    end

endmodule
`default_nettype wire
